// File: rtl/ltssm_detect_ctrl.sv
// ltssm_detect_ctrl: LTSSM Detect.Quiet / Detect.Active sequencer.
// Drives the shared PIPE timer and collects per-lane receiver-detect results.
module ltssm_detect_ctrl #(
    parameter int LANES = 16
) (
    input  logic                 Pclk,
    input  logic                 Reset,
    input  logic                 Enable,
    output logic                 TimerStart,
    output logic                 TimerEnable,
    output logic [2:0]           TimerIntervalCode,
    input  logic                 TimeOut,
    input  logic [LANES-1:0]     RxElecIdle,
    output logic                 TxDetectRx,
    input  logic [LANES-1:0]     PhyStatus,
    input  logic [3*LANES-1:0]   RxStatus,
    output logic                 DetectDone,
    output logic [LANES-1:0]     LanesDetected
);

    typedef enum logic [2:0] {
        IDLE, QUIET, ACTIVE1, WAIT12, ACTIVE2, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [LANES-1:0] seen, found, first_set, present, result;
    logic             in_active, all_seen, load_det, load_first, timed_nxt;

    always_comb begin
        present = '0;
        for (int i = 0; i < LANES; i++)
            present[i] = (RxStatus[3*i +: 3] == 3'b011);
    end

    assign in_active = (state == ACTIVE1) || (state == ACTIVE2);
    assign all_seen  = &seen;
    assign result    = found & first_set;

    always_comb begin
        state_nxt  = state;
        load_det   = 1'b0;
        load_first = 1'b0;
        unique case (state)
            IDLE:    if (Enable) state_nxt = QUIET;
            QUIET:   if (!TimerStart && (TimeOut || !(&RxElecIdle)))
                         state_nxt = ACTIVE1;
            ACTIVE1: if (all_seen) begin
                         if (found == '0) begin
                             state_nxt = QUIET;
                         end else if (&found) begin
                             state_nxt = DONE;
                             load_det  = 1'b1;
                         end else begin
                             state_nxt  = WAIT12;
                             load_first = 1'b1;
                         end
                     end
            WAIT12:  if (!TimerStart && TimeOut) state_nxt = ACTIVE2;
            ACTIVE2: if (all_seen) begin
                         if (result == '0) begin
                             state_nxt = QUIET;
                         end else begin
                             state_nxt = DONE;
                             load_det  = 1'b1;
                         end
                     end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        // Dropping Enable overrides any evaluation in the same cycle
        if (!Enable) begin
            state_nxt  = IDLE;
            load_det   = 1'b0;
            load_first = 1'b0;
        end
    end

    assign timed_nxt = (state_nxt == QUIET) || (state_nxt == WAIT12);

    always_ff @(posedge Pclk or negedge Reset) begin
        if (!Reset) begin
            state             <= IDLE;
            TimerStart        <= 1'b0;
            TimerEnable       <= 1'b0;
            TimerIntervalCode <= 3'b000;
            TxDetectRx        <= 1'b0;
            DetectDone        <= 1'b0;
            LanesDetected     <= '0;
            seen              <= '0;
            found             <= '0;
            first_set         <= '0;
        end else begin
            state             <= state_nxt;
            TimerStart        <= timed_nxt && (state_nxt != state);
            TimerEnable       <= timed_nxt;
            TimerIntervalCode <= timed_nxt ? 3'b001 : 3'b000;
            TxDetectRx        <= (state_nxt == ACTIVE1) ||
                                 (state_nxt == ACTIVE2);
            DetectDone        <= (state_nxt == DONE) && (state != DONE);
            // Only the first PhyStatus of a lane counts in each pass
            if (in_active) begin
                seen  <= seen | PhyStatus;
                found <= found | (PhyStatus & ~seen & present);
            end else begin
                seen  <= '0;
                found <= '0;
            end
            if (load_first)
                first_set <= found;
            if (load_det)
                LanesDetected <= (state == ACTIVE1) ? found : result;
        end
    end

endmodule

// File: tb/tb_ltssm_detect_ctrl.sv
// tb_ltssm_detect_ctrl: scenario tasks plus randomized detect passes
// checked against a set-arithmetic model of the Detect outcome.
module tb_ltssm_detect_ctrl;
    localparam int LANES = 4;

    logic                 Pclk, Reset, Enable, TimeOut;
    logic                 TimerStart, TimerEnable, TxDetectRx, DetectDone;
    logic [2:0]           TimerIntervalCode;
    logic [LANES-1:0]     RxElecIdle, PhyStatus, LanesDetected;
    logic [3*LANES-1:0]   RxStatus;
    int                   total, bad;

    ltssm_detect_ctrl #(.LANES(LANES)) dut (
        .Pclk              (Pclk),
        .Reset             (Reset),
        .Enable            (Enable),
        .TimerStart        (TimerStart),
        .TimerEnable       (TimerEnable),
        .TimerIntervalCode (TimerIntervalCode),
        .TimeOut           (TimeOut),
        .RxElecIdle        (RxElecIdle),
        .TxDetectRx        (TxDetectRx),
        .PhyStatus         (PhyStatus),
        .RxStatus          (RxStatus),
        .DetectDone        (DetectDone),
        .LanesDetected     (LanesDetected)
    );

    initial Pclk = 1'b0;
    always #5 Pclk = ~Pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    function automatic logic [2:0] bad_code();
        logic [2:0] c;
        c = 3'($urandom_range(0, 7));
        if (c == 3'b011) c = 3'b000;
        return c;
    endfunction

    task automatic tick();
        @(negedge Pclk);
    endtask

    task automatic enter_quiet(output logic ts, output logic te,
                               output logic [2:0] code);
        Enable = 1'b1;
        tick();
        ts   = TimerStart;
        te   = TimerEnable;
        code = TimerIntervalCode;
    endtask

    // Waits w cycles with stray PhyStatus noise, then pulses TimeOut
    task automatic fire_timeout(input int w, output int tsc,
                                output logic tx, output logic te);
        tsc = 0;
        for (int i = 0; i < w; i++) begin
            PhyStatus = 4'($urandom);
            RxStatus  = 12'($urandom);
            tick();
            if (TimerStart) tsc++;
        end
        PhyStatus = '0;
        TimeOut   = 1'b1;
        tick();
        TimeOut = 1'b0;
        tx = TxDetectRx;
        te = TimerEnable;
    endtask

    // Lane i reports at offset ai; returns outputs of the first
    // cycle after the evaluation edge
    task automatic do_pass(input logic [3:0] ok,
                           input int a0, input int a1,
                           input int a2, input int a3,
                           input int dup_t,
                           output int txc, output int ddc,
                           output logic ts, output logic dd,
                           output logic te, output logic [3:0] ld);
        int a [4];
        int mx;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        mx = 0;
        for (int i = 0; i < LANES; i++) if (a[i] > mx) mx = a[i];
        txc = 0;
        ddc = 0;
        for (int t = 0; t <= mx + 1; t++) begin
            if (TxDetectRx) txc++;
            if (DetectDone) ddc++;
            PhyStatus = '0;
            for (int i = 0; i < LANES; i++) begin
                RxStatus[3*i +: 3] = bad_code();
                if (a[i] == t) begin
                    PhyStatus[i] = 1'b1;
                    if (ok[i]) RxStatus[3*i +: 3] = 3'b011;
                end
            end
            if (t == dup_t) begin
                PhyStatus[0] = 1'b1;
                RxStatus[2:0] = ok[0] ? bad_code() : 3'b011;
            end
            tick();
        end
        PhyStatus = '0;
        if (TxDetectRx) txc++;
        ts = TimerStart;
        dd = DetectDone;
        te = TimerEnable;
        ld = LanesDetected;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Enable = 1'b0; TimeOut = 1'b0;
        RxElecIdle = 4'hF; PhyStatus = '0; RxStatus = '0;
        #1;
        total++;
        if ({TimerStart, TimerEnable, TimerIntervalCode, TxDetectRx,
             DetectDone, LanesDetected} !== 11'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0",
                     {TimerStart, TimerEnable, TimerIntervalCode,
                      TxDetectRx, DetectDone, LanesDetected});
        end
        tick(); tick();
        Reset = 1'b1;
        tick(); tick();
        total++;
        if ({TimerStart, TimerEnable, TxDetectRx, DetectDone} !== 4'b0) begin
            bad++;
            $display("FAIL idle_no_enable: got %b want 0",
                     {TimerStart, TimerEnable, TxDetectRx, DetectDone});
        end
    endtask

    task automatic test_all_found();
        logic ts, te, tx, dd;
        logic [2:0] code;
        logic [3:0] ld;
        int tsc, txc, ddc;
        enter_quiet(ts, te, code);
        total++;
        if ({ts, te, code} !== 5'b11001) begin
            bad++;
            $display("FAIL quiet_entry: got %b want 11001", {ts, te, code});
        end
        fire_timeout(5, tsc, tx, te);
        total++;
        if (tsc !== 0 || {tx, te} !== 2'b10) begin
            bad++;
            $display("FAIL active1_entry: got tsc=%0d tx/te=%b want 0 10",
                     tsc, {tx, te});
        end
        do_pass(4'hF, 0, 0, 0, 0, -1, txc, ddc, ts, dd, te, ld);
        total++;
        if (txc !== 2 || ddc !== 0 || {ts, dd, te, ld} !== 7'b0101111) begin
            bad++;
            $display("FAIL all_found: got txc=%0d ddc=%0d %b want 2 0 0101111",
                     txc, ddc, {ts, dd, te, ld});
        end
        tick();
        total++;
        if ({DetectDone, TxDetectRx, LanesDetected} !== 6'b001111) begin
            bad++;
            $display("FAIL done_one_cycle: got %b want 001111",
                     {DetectDone, TxDetectRx, LanesDetected});
        end
    endtask

    task automatic test_none_found();
        logic ts, te, tx, dd;
        logic [2:0] code;
        logic [3:0] ld;
        int tsc, txc, ddc;
        Enable = 1'b0; tick();
        enter_quiet(ts, te, code);
        fire_timeout(6, tsc, tx, te);
        do_pass(4'h0, 0, 2, 1, 0, -1, txc, ddc, ts, dd, te, ld);
        total++;
        if (txc !== 4 || ddc !== 0 || {ts, dd, te, ld} !== 7'b1011111) begin
            bad++;
            $display("FAIL none_found: got txc=%0d ddc=%0d %b want 4 0 1011111",
                     txc, ddc, {ts, dd, te, ld});
        end
        tick();
        total++;
        if ({TimerStart, DetectDone, TimerIntervalCode} !== 5'b00001) begin
            bad++;
            $display("FAIL requiet_timer: got %b want 00001",
                     {TimerStart, DetectDone, TimerIntervalCode});
        end
    endtask

    task automatic test_two_pass();
        logic ts, te, tx, dd;
        logic [2:0] code;
        logic [3:0] ld;
        int tsc, txc, ddc, txw;
        Enable = 1'b0; tick();
        enter_quiet(ts, te, code);
        fire_timeout(3, tsc, tx, te);
        do_pass(4'b0011, 1, 0, 2, 1, -1, txc, ddc, ts, dd, te, ld);
        total++;
        if (txc !== 4 || {ts, dd, te, TimerIntervalCode} !== 6'b101001) begin
            bad++;
            $display("FAIL wait12_entry: got txc=%0d %b want 4 101001",
                     txc, {ts, dd, te, TimerIntervalCode});
        end
        txw = 0;
        RxElecIdle = 4'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (TxDetectRx) txw++;
        end
        RxElecIdle = 4'hF;
        total++;
        if (txw !== 0) begin
            bad++;
            $display("FAIL wait12_elecidle: got tx_cycles=%0d want 0", txw);
        end
        fire_timeout(3, tsc, tx, te);
        total++;
        if (tsc !== 0 || tx !== 1'b1) begin
            bad++;
            $display("FAIL active2_entry: got tsc=%0d tx=%b want 0 1", tsc, tx);
        end
        do_pass(4'b0111, 0, 0, 0, 0, -1, txc, ddc, ts, dd, te, ld);
        total++;
        if ({dd, ld} !== 5'b10011) begin
            bad++;
            $display("FAIL two_pass: got %b want 10011", {dd, ld});
        end
    endtask

    task automatic test_enable_drop();
        tick(); tick();
        total++;
        if ({DetectDone, TimerEnable, LanesDetected} !== 6'b000011) begin
            bad++;
            $display("FAIL done_hold: got %b want 000011",
                     {DetectDone, TimerEnable, LanesDetected});
        end
        Enable = 1'b0;
        tick();
        total++;
        if ({TxDetectRx, TimerEnable, DetectDone, TimerStart,
             LanesDetected} !== 8'b00000011) begin
            bad++;
            $display("FAIL enable_drop: got %b want 00000011",
                     {TxDetectRx, TimerEnable, DetectDone, TimerStart,
                      LanesDetected});
        end
    endtask

    task automatic test_elec_idle();
        logic ts, te, dd;
        logic [2:0] code;
        logic [3:0] ld;
        int tsc, txq, txc, ddc;
        enter_quiet(ts, te, code);
        tsc = 0; txq = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (TimerStart) tsc++;
            if (TxDetectRx) txq++;
        end
        RxElecIdle = 4'b1011;
        tick();
        RxElecIdle = 4'hF;
        total++;
        if (tsc !== 0 || txq !== 0 || {TxDetectRx, TimerEnable} !== 2'b10) begin
            bad++;
            $display("FAIL elec_idle_exit: got tsc=%0d txq=%0d %b want 0 0 10",
                     tsc, txq, {TxDetectRx, TimerEnable});
        end
        do_pass(4'hF, 2, 0, 1, 0, -1, txc, ddc, ts, dd, te, ld);
        total++;
        if (txc !== 4 || {dd, ld} !== 5'b11111) begin
            bad++;
            $display("FAIL elec_idle_done: got txc=%0d %b want 4 11111",
                     txc, {dd, ld});
        end
    endtask

    task automatic test_staggered();
        logic ts, te, tx, dd;
        logic [2:0] code;
        logic [3:0] ld;
        int tsc, txc, ddc;
        Enable = 1'b0; tick();
        enter_quiet(ts, te, code);
        fire_timeout(3, tsc, tx, te);
        do_pass(4'b1101, 0, 1, 2, 3, 2, txc, ddc, ts, dd, te, ld);
        total++;
        if (txc !== 5 || ddc !== 0 || {ts, dd} !== 2'b10) begin
            bad++;
            $display("FAIL staggered_eval: got txc=%0d ddc=%0d %b want 5 0 10",
                     txc, ddc, {ts, dd});
        end
        fire_timeout(2, tsc, tx, te);
        do_pass(4'hF, 0, 0, 0, 0, -1, txc, ddc, ts, dd, te, ld);
        total++;
        if ({dd, ld} !== 5'b11101) begin
            bad++;
            $display("FAIL staggered_dup: got %b want 11101", {dd, ld});
        end
    endtask

    task automatic test_enable_at_eval();
        logic ts, te, tx;
        logic [2:0] code;
        int tsc;
        Enable = 1'b0; tick();
        enter_quiet(ts, te, code);
        fire_timeout(2, tsc, tx, te);
        PhyStatus = 4'hF;
        RxStatus  = 12'h6DB;
        tick();
        PhyStatus = '0;
        Enable    = 1'b0;
        tick();
        total++;
        if ({TxDetectRx, TimerEnable, DetectDone, LanesDetected} !== 7'b0001101) begin
            bad++;
            $display("FAIL enable_eval: got %b want 0001101",
                     {TxDetectRx, TimerEnable, DetectDone, LanesDetected});
        end
        tick();
        total++;
        if (DetectDone !== 1'b0) begin
            bad++;
            $display("FAIL enable_eval_late: got %b want 0", DetectDone);
        end
    endtask

    task automatic test_reset_active();
        logic ts, te, tx;
        logic [2:0] code;
        int tsc;
        Enable = 1'b1; tick();
        enter_quiet(ts, te, code);
        fire_timeout(4, tsc, tx, te);
        PhyStatus = 4'b0001;
        RxStatus  = 12'h003;
        tick();
        PhyStatus = '0;
        #2 Reset = 1'b0;
        #1;
        total++;
        if ({TxDetectRx, TimerStart, TimerEnable, TimerIntervalCode,
             DetectDone, LanesDetected} !== 11'b0) begin
            bad++;
            $display("FAIL reset_active: got %b want 0",
                     {TxDetectRx, TimerStart, TimerEnable, TimerIntervalCode,
                      DetectDone, LanesDetected});
        end
        Enable = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        total++;
        if ({TxDetectRx, TimerEnable, DetectDone, LanesDetected} !== 7'b0) begin
            bad++;
            $display("FAIL reset_release: got %b want 0",
                     {TxDetectRx, TimerEnable, DetectDone, LanesDetected});
        end
    endtask

    task automatic test_random();
        logic ts, te, tx, dd;
        logic [2:0] code;
        logic [3:0] ld, ok1, ok2, res, model_ld;
        int tsc, txc, ddc, mx;
        int a [4];
        model_ld = 4'h0;
        for (int it = 0; it < 24; it++) begin
            Enable = 1'b0; tick();
            enter_quiet(ts, te, code);
            fire_timeout($urandom_range(1, 8), tsc, tx, te);
            total++;
            if (tsc !== 0 || tx !== 1'b1) begin
                bad++;
                $display("FAIL rnd_active1 it=%0d: got tsc=%0d tx=%b want 0 1",
                         it, tsc, tx);
            end
            case (it % 4)
                0: ok1 = 4'h0;
                1: ok1 = 4'hF;
                default: ok1 = 4'($urandom);
            endcase
            mx = 0;
            for (int i = 0; i < LANES; i++) begin
                a[i] = $urandom_range(0, 3);
                if (a[i] > mx) mx = a[i];
            end
            do_pass(ok1, a[0], a[1], a[2], a[3], -1, txc, ddc, ts, dd, te, ld);
            total++;
            if (txc !== mx + 2 || ddc !== 0) begin
                bad++;
                $display("FAIL rnd_tx_window it=%0d: got %0d/%0d want %0d/0",
                         it, txc, ddc, mx + 2);
            end
            if (ok1 == 4'h0) begin
                total++;
                if ({ts, dd, ld} !== {2'b10, model_ld}) begin
                    bad++;
                    $display("FAIL rnd_none it=%0d: got %b want %b",
                             it, {ts, dd, ld}, {2'b10, model_ld});
                end
            end else if (ok1 == 4'hF) begin
                model_ld = 4'hF;
                total++;
                if ({ts, dd, ld} !== 6'b011111) begin
                    bad++;
                    $display("FAIL rnd_all it=%0d: got %b want 011111",
                             it, {ts, dd, ld});
                end
            end else begin
                total++;
                if ({ts, dd} !== 2'b10) begin
                    bad++;
                    $display("FAIL rnd_wait12 it=%0d: got %b want 10",
                             it, {ts, dd});
                end
                fire_timeout($urandom_range(1, 6), tsc, tx, te);
                ok2 = 4'($urandom);
                res = ok1 & ok2;
                for (int i = 0; i < LANES; i++) a[i] = $urandom_range(0, 2);
                do_pass(ok2, a[0], a[1], a[2], a[3], -1,
                        txc, ddc, ts, dd, te, ld);
                if (res != 4'h0) model_ld = res;
                total++;
                if ({ts, dd, ld} !== {res == 4'h0, res != 4'h0, model_ld}) begin
                    bad++;
                    $display("FAIL rnd_pass2 it=%0d: got %b want %b", it,
                             {ts, dd, ld},
                             {res == 4'h0, res != 4'h0, model_ld});
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_all_found();
        test_none_found();
        test_two_pass();
        test_enable_drop();
        test_elec_idle();
        test_staggered();
        test_enable_at_eval();
        test_reset_active();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
